conveyor_read_pipeline: RTL
===========================

Name: conveyor_read_pipeline

Overview:
Upstream feeder for the conveyor control stage. It accepts read requests from decode, each tagged with a target conveyor (main or interrupt) and slot. It issues the reads to the data memory port with a valid/ready handshake and tracks in-order outstanding reads in a tag FIFO. Each returned word is delivered as a registered conveyor slot write carrying finished=1 plus a fault code.

Parameters:
WORD_WIDTH, 32, data/address word width
CONVEYOR_ADDR_WIDTH, 4, conveyor slot index width (16 slots)
DEPTH_ADDR_WIDTH, 2, log2 of max outstanding reads (DEPTH = 4)
BUS_FAULT, 3'd3, fault code written to the slot on a memory error response (width 3, matches FAULT_ADDR_WIDTH)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
issue_valid  input  1  decode presents a read
issue_ready  output  1  block accepts the read this cycle
issue_addr  input  WORD_WIDTH  memory address
issue_conveyor  input  1  target conveyor (0 main, 1 interrupt)
issue_slot  input  CONVEYOR_ADDR_WIDTH  target slot (decode passes conveyor_back1)
mem_req_valid  output  1  request to memory
mem_req_ready  input  1  memory accepts request
mem_req_addr  output  WORD_WIDTH  request address
mem_resp_valid  input  1  in-order response strobe
mem_resp_data  input  WORD_WIDTH  response word
mem_resp_error  input  1  bus error on this response
cv_write  output  1  conveyor slot write strobe
cv_write_conveyor  output  1  target conveyor
cv_write_slot  output  CONVEYOR_ADDR_WIDTH  target slot
cv_write_value  output  WORD_WIDTH  word (0 on error)
cv_write_fault  output  3  F_NONE or BUS_FAULT
outstanding  output  DEPTH_ADDR_WIDTH+1  tags in flight
protocol_error  output  1  sticky: response with empty tag FIFO

Behaviour:
- Reset (asynchronous, any cycle, including mid-operation):
  - All outputs 0.
  - FIFO pointers and count cleared; in-flight tags discarded.
  - Memory shares this reset and must drop its in-flight responses.
- Request register: single entry {valid, addr}.
  - Occupied entry holds mem_req_valid/mem_req_addr stable until mem_req_valid && mem_req_ready.
- issue_ready = (count < DEPTH) && (!mem_req_valid || mem_req_ready). Combinational, and must not depend on issue_valid.
- Accept = issue_valid && issue_ready. On accept:
  - The request register loads issue_addr; mem_req_valid=1 from the next cycle. Issue-to-request latency is 1 cycle.
  - Push {issue_conveyor, issue_slot} into the tag FIFO.
- Count = tags pushed minus tags popped, 0..DEPTH; drives outstanding.
  - A push and a pop in the same cycle leave count unchanged.
  - Full blocks a push even if a pop happens the same cycle. This avoids any combinational path from mem_resp_valid to issue_ready.
- Response with count>0: pop the head tag. Next cycle:
  - cv_write=1 with the popped conveyor and slot.
  - If mem_resp_error=0: value = mem_resp_data, fault = F_NONE.
  - If mem_resp_error=1: value = 0, fault = BUS_FAULT.
  - cv_write is a one-cycle pulse; response-to-write latency is 1 cycle. Back-to-back responses give back-to-back writes.
- Response with count==0: ignored (no pop, no write); protocol_error set and held until reset.
- Pointers wrap modulo DEPTH.
- Tag order equals issue order; memory guarantees in-order responses.
- A response may arrive in the cycle after the request handshake at the earliest. The same-cycle handshake+response case is illegal for memory.
- Slot indices are stored verbatim. Slot wrap (head-1 at head=0 yields 15) is the decoder's responsibility; the block does no arithmetic on slots.
- No flush input; interrupt switching needs none, because each tag carries its conveyor bit.

Test Plan:
- Single read: issue addr 0x100, conveyor 0, slot 15, mem_req_ready=1, response 0xDEADBEEF two cycles later -> mem_req_valid high one cycle with addr 0x100; cv_write pulse the cycle after the response with conveyor 0, slot 15, value 0xDEADBEEF, fault F_NONE; outstanding 1 then 0.
- Backpressure: mem_req_ready=0 for 5 cycles after issue of 0x200 -> mem_req_addr stable at 0x200; issue_ready=0 while the register is held; exactly one request handshake.
- Fill: four issues to slots 3,2,1,0 with no responses -> outstanding=4, issue_ready=0. Then four responses 0xA..0xD -> writes to slots 3,2,1,0 in order with matching values.
- Mixed conveyors: issue to conveyor 1 slot 14, then conveyor 0 slot 7; responses 0x11, 0x22 -> writes (1,14,0x11) then (0,7,0x22).
- Error and spurious: response with mem_resp_error=1 -> write value 0, fault 3'd3. Extra response with outstanding=0 -> no write; protocol_error=1 and held until reset.
- Reset mid-flight: assert reset asynchronously with 3 reads outstanding and mem_req_valid=1 -> all outputs 0 immediately; after release, outstanding=0, issue_ready=1, protocol_error=0.

Source files
------------

// File: rtl/conveyor_read_pipeline.sv
// rtl/conveyor_read_pipeline.sv - issues conveyor reads to memory and returns words as slot writes
// Requests go through a one-entry register; destination tags wait in an in-order FIFO until the response.
module conveyor_read_pipeline #(
  parameter int         WORD_WIDTH          = 32,
  parameter int         CONVEYOR_ADDR_WIDTH = 4,
  parameter int         DEPTH_ADDR_WIDTH    = 2,
  parameter logic [2:0] BUS_FAULT           = 3'd3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           issue_valid,
  output logic                           issue_ready,
  input  logic [WORD_WIDTH-1:0]          issue_addr,
  input  logic                           issue_conveyor,
  input  logic [CONVEYOR_ADDR_WIDTH-1:0] issue_slot,
  output logic                           mem_req_valid,
  input  logic                           mem_req_ready,
  output logic [WORD_WIDTH-1:0]          mem_req_addr,
  input  logic                           mem_resp_valid,
  input  logic [WORD_WIDTH-1:0]          mem_resp_data,
  input  logic                           mem_resp_error,
  output logic                           cv_write,
  output logic                           cv_write_conveyor,
  output logic [CONVEYOR_ADDR_WIDTH-1:0] cv_write_slot,
  output logic [WORD_WIDTH-1:0]          cv_write_value,
  output logic [2:0]                     cv_write_fault,
  output logic [DEPTH_ADDR_WIDTH:0]      outstanding,
  output logic                           protocol_error
);

  localparam int                      DEPTH       = 1 << DEPTH_ADDR_WIDTH;
  localparam logic [DEPTH_ADDR_WIDTH:0] DEPTH_COUNT = (DEPTH_ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [2:0]              F_NONE      = 3'd0;

  logic                           req_valid;
  logic [WORD_WIDTH-1:0]          req_addr;
  logic [DEPTH_ADDR_WIDTH:0]      count;
  logic [DEPTH_ADDR_WIDTH-1:0]    wr_ptr;
  logic [DEPTH_ADDR_WIDTH-1:0]    rd_ptr;
  logic                           tag_conveyor [DEPTH];
  logic [CONVEYOR_ADDR_WIDTH-1:0] tag_slot     [DEPTH];
  logic                           accept;
  logic                           pop;

  // Full blocks a push regardless of a same-cycle pop, keeping mem_resp_valid off this path.
  assign issue_ready   = !reset && (count < DEPTH_COUNT) && (!req_valid || mem_req_ready);
  assign accept        = issue_valid && issue_ready;
  assign pop           = mem_resp_valid && (count != '0);
  assign mem_req_valid = req_valid;
  assign mem_req_addr  = req_addr;
  assign outstanding   = count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_valid <= 1'b0;
      req_addr  <= '0;
    end else if (accept) begin
      req_valid <= 1'b1;
      req_addr  <= issue_addr;
    end else if (req_valid && mem_req_ready) begin
      req_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      tag_conveyor[wr_ptr] <= issue_conveyor;
      tag_slot[wr_ptr]     <= issue_slot;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cv_write          <= 1'b0;
      cv_write_conveyor <= 1'b0;
      cv_write_slot     <= '0;
      cv_write_value    <= '0;
      cv_write_fault    <= F_NONE;
      protocol_error    <= 1'b0;
    end else begin
      cv_write <= pop;
      if (pop) begin
        cv_write_conveyor <= tag_conveyor[rd_ptr];
        cv_write_slot     <= tag_slot[rd_ptr];
        cv_write_value    <= mem_resp_error ? '0 : mem_resp_data;
        cv_write_fault    <= mem_resp_error ? BUS_FAULT : F_NONE;
      end
      if (mem_resp_valid && (count == '0)) protocol_error <= 1'b1;
    end
  end

endmodule
